pixel_feeder: RTL and testbench

Upstream stage of the `vga` scan-out block. It accepts the Mandelbrot engine's RGB565 pixel stream over a valid/ready handshake and packs it into the 1280-bit, 80-pixel double-half `storage` window that `vga` reads. When `vga` signals on `need_pixel` that a 40-pixel half has been consumed, the block refills that half. It raises `start` once the window is first full and restarts the fill on `zoom`.

---
 rtl/pixel_feeder_pkg.sv | 22 ++
 rtl/pixel_feeder_if.sv | 10 +
 rtl/pixel_feeder.sv | 112 +++++++++++
 tb/tb_pixel_feeder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_feeder_pkg.sv
// Shared types and constants for pixel_feeder: state encoding, window geometry,
// write-index landmarks and the saturating pixel-count update.
package pixel_feeder_pkg;
  localparam int PIX_W    = 16;
  localparam int HALF_PIX = 40;
  localparam int WIN_PIX  = 2 * HALF_PIX;

  localparam logic [6:0] IDX_TOP     = 7'd79;
  localparam logic [6:0] IDX_MID     = 7'd40;
  localparam logic [6:0] IDX_LOW_TOP = 7'd39;

  typedef enum logic [1:0] {FILL_INIT, IDLE, FILL_HI, FILL_LO} state_t;

  // +1 per accepted pixel, -HALF_PIX per request, floored at zero
  function automatic logic [10:0] count_next(input logic [10:0] c, input logic inc,
                                             input logic dec);
    int v;
    v = int'(c) + (inc ? 1 : 0) - (dec ? HALF_PIX : 0);
    if (v < 0) v = 0;
    return 11'(v);
  endfunction
endpackage

// File: rtl/pixel_feeder_if.sv
// Engine-to-feeder pixel stream: RGB565 data with a valid/ready handshake.
interface pixel_feeder_if;
  import pixel_feeder_pkg::*;
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;

  modport master (output pix_data, pix_valid, input pix_ready);
  modport slave  (input pix_data, pix_valid, output pix_ready);
endinterface

// File: rtl/pixel_feeder.sv
// Packs the pixel stream into the 80-pixel double-half window scanned by vga and
// refills halves on request. PIXEL_FEEDER_UNDERRUN_EN builds sticky underrun detection.
module pixel_feeder
  import pixel_feeder_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     zoom,
  pixel_feeder_if.slave            pix,
  input  logic [1:0]               need_pixel,
  output logic [WIN_PIX*PIX_W-1:0] storage,
  output logic [10:0]              store_coun,
  output logic                     start,
  output logic                     underrun
);
  state_t     state, state_n;
  logic [6:0] wr_idx, wr_idx_n;
  logic       pend_hi, pend_lo, pend_hi_n, pend_lo_n;
  logic       start_n;
  logic [10:0] coun_n;
  logic       acc, req_hi, req_lo;
  logic [WIN_PIX-1:0][PIX_W-1:0] win;

  assign pix.pix_ready = rst_n && (state != IDLE) && !zoom;
  assign acc           = pix.pix_valid && pix.pix_ready;
  // vga requests only matter once the window has been primed
  assign req_hi  = (state != FILL_INIT) && !zoom && (need_pixel == 2'd1);
  assign req_lo  = (state != FILL_INIT) && !zoom && (need_pixel == 2'd2);
  assign storage = win;

  always_comb begin
    state_n   = state;
    wr_idx_n  = wr_idx;
    pend_hi_n = pend_hi | req_hi;
    pend_lo_n = pend_lo | req_lo;
    start_n   = start;
    coun_n    = count_next(store_coun, acc, req_hi | req_lo);
    if (zoom) begin
      state_n   = FILL_INIT;
      wr_idx_n  = IDX_TOP;
      pend_hi_n = 1'b0;
      pend_lo_n = 1'b0;
      start_n   = 1'b0;
      coun_n    = '0;
    end else begin
      case (state)
        FILL_INIT: if (acc) begin
          if (wr_idx == 7'd0) begin
            state_n = IDLE;
            start_n = 1'b1;
          end else wr_idx_n = wr_idx - 7'd1;
        end
        IDLE: begin
          if (pend_hi) begin
            state_n = FILL_HI; wr_idx_n = IDX_TOP; pend_hi_n = req_hi;
          end else if (pend_lo) begin
            state_n = FILL_LO; wr_idx_n = IDX_LOW_TOP; pend_lo_n = req_lo;
          end
        end
        FILL_HI: if (acc) begin
          if (wr_idx == IDX_MID) begin
            if (pend_lo) begin
              state_n = FILL_LO; wr_idx_n = IDX_LOW_TOP; pend_lo_n = req_lo;
            end else state_n = IDLE;
          end else wr_idx_n = wr_idx - 7'd1;
        end
        FILL_LO: if (acc) begin
          if (wr_idx == 7'd0) begin
            if (pend_hi) begin
              state_n = FILL_HI; wr_idx_n = IDX_TOP; pend_hi_n = req_hi;
            end else state_n = IDLE;
          end else wr_idx_n = wr_idx - 7'd1;
        end
        default: state_n = FILL_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL_INIT;
      wr_idx     <= IDX_TOP;
      pend_hi    <= 1'b0;
      pend_lo    <= 1'b0;
      start      <= 1'b0;
      store_coun <= '0;
      win        <= '0;
    end else begin
      state      <= state_n;
      wr_idx     <= wr_idx_n;
      pend_hi    <= pend_hi_n;
      pend_lo    <= pend_lo_n;
      start      <= start_n;
      store_coun <= coun_n;
      if (acc) win[wr_idx] <= pix.pix_data;
    end
  end

`ifdef PIXEL_FEEDER_UNDERRUN_EN
  logic dup;
  // a half asked for again while still queued or in flight was displayed stale
  assign dup = (req_hi && (pend_hi || state == FILL_HI)) ||
               (req_lo && (pend_lo || state == FILL_LO));

  always_ff @(posedge clk) begin
    if (!rst_n)   underrun <= 1'b0;
    else if (dup) underrun <= 1'b1;
  end
`else
  assign underrun = 1'b0;
`endif
endmodule

// File: tb/tb_pixel_feeder.sv
// Randomized scoreboard bench for pixel_feeder: a queue-of-indices reference model
// predicts the window, count, start and underrun after every clock edge.
module tb_pixel_feeder;
  logic        clk = 1'b0;
  logic        rst_n, zoom;
  logic [1:0]  need_pixel;
  logic [1279:0] storage;
  logic [10:0] store_coun;
  logic        start, underrun;

  pixel_feeder_if pif();

  pixel_feeder dut (
    .clk(clk), .rst_n(rst_n), .zoom(zoom), .pix(pif.slave), .need_pixel(need_pixel),
    .storage(storage), .store_coun(store_coun), .start(start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            tag;
    logic [1279:0] win;
    logic [10:0]   coun;
    logic          start;
    logic          under;
  } exp_t;
  exp_t sbq[$];

  // Reference model: the ordered list of window indices still to be written
  int          idxq[$];
  logic [15:0] mwin[80];
  int          mcoun;
  bit          mstart, munder;

  task automatic check(input string nm, input logic [1279:0] act, input logic [1279:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic void init_q();
    idxq.delete();
    for (int i = 79; i >= 0; i--) idxq.push_back(i);
  endfunction

  function automatic bit has_half(input bit hi);
    foreach (idxq[k]) if (hi ? (idxq[k] >= 40) : (idxq[k] < 40)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit has_idx(input int v);
    foreach (idxq[k]) if (idxq[k] == v) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive inputs, predict the effect of the coming edge, push it
  task automatic step(input bit r, input bit z, input bit v, input logic [15:0] d,
                      input logic [1:0] need, output bit acc);
    bit rdy, rq;
    exp_t e;
    rst_n = r; zoom = z; pif.pix_valid = v; pif.pix_data = d; need_pixel = need;
    #1;
    rdy = pif.pix_ready;
    acc = 1'b0;
    if (!r) begin
      check("ready_in_reset", rdy, 0);
      init_q();
      foreach (mwin[k]) mwin[k] = '0;
      mcoun = 0; mstart = 0; munder = 0;
    end else if (z) begin
      check("ready_in_zoom", rdy, 0);
      init_q();
      mcoun = 0; mstart = 0;
    end else begin
      if (rdy) check("ready_has_work", idxq.size() != 0, 1);
      rq = mstart && (need == 2'd1 || need == 2'd2);
      if (rq) begin
        if (has_half(need == 2'd1)) begin
`ifdef PIXEL_FEEDER_UNDERRUN_EN
          munder = 1;
`endif
        end
        if (!has_idx(need == 2'd1 ? 79 : 39))
          for (int i = (need == 2'd1 ? 79 : 39); i >= (need == 2'd1 ? 40 : 0); i--)
            idxq.push_back(i);
      end
      acc = v && rdy && (idxq.size() != 0);
      if (acc) begin
        mwin[idxq.pop_front()] = d;
        mcoun++;
        if (!mstart && idxq.size() == 0) mstart = 1;
      end
      if (rq) mcoun -= 40;
      if (mcoun < 0) mcoun = 0;
    end
    e.tag = cyc;
    for (int i = 0; i < 80; i++) e.win[i*16 +: 16] = mwin[i];
    e.coun = 11'(mcoun); e.start = mstart; e.under = munder;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].tag < cyc) begin
      e = sbq.pop_front();
      check("storage", storage, e.win);
      check("store_coun", store_coun, e.coun);
      check("start", start, e.start);
      check("underrun", underrun, e.under);
    end
  end

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1, 0, 0, '0, 2'd0, a);
  endtask

  // Feed n pixels with valid held high; running out of budget is a failure
  task automatic feed(input int n, input int limit, input string nm);
    bit a;
    int got = 0, t = 0;
    while (got < n && t < limit) begin
      step(1, 0, 1, 16'($urandom), 2'd0, a);
      got += int'(a);
      t++;
    end
    check(nm, got, n);
  endtask

  initial begin
    bit a;
    int first, last, got;
    logic [1:0] nd;
    init_q();
    foreach (mwin[k]) mwin[k] = '0;
    mcoun = 0; mstart = 0; munder = 0;
    pif.pix_valid = 0; pif.pix_data = '0; zoom = 0; need_pixel = 0; rst_n = 0;

    step(0, 0, 1, 16'h1234, 2'd0, a);
    step(0, 0, 0, '0, 2'd0, a);

    // Prime with 0x0000..0x004F, one pixel per clock
    for (int i = 0; i < 80; i++) begin
      step(1, 0, 1, 16'(i), 2'd0, a);
      check("prime_accept", a, 1);
    end
    check("prime_top_pixel", storage[1279:1264], 16'h0000);
    check("prime_bottom_pixel", storage[15:0], 16'h004F);
    check("prime_start", start, 1);
    check("prime_count", store_coun, 80);
    idle(2);

    // Upper-half refill with red
    step(1, 0, 0, '0, 2'd1, a);
    idle(2);
    got = 0;
    for (int t = 0; t < 60 && got < 40; t++) begin
      step(1, 0, 1, 16'hF800, 2'd0, a);
      got += int'(a);
    end
    check("hi_refill_count", got, 40);
    idle(2);
    check("hi_refill_low_kept", storage[15:0], 16'h004F);

    // Back-to-back hi then lo refill with valid held high
    got = 0; first = -1; last = -1;
    for (int t = 0; t < 100 && got < 80; t++) begin
      nd = (t == 0) ? 2'd1 : (t == 2) ? 2'd2 : 2'd0;
      step(1, 0, 1, 16'($urandom), nd, a);
      if (a) begin
        if (first < 0) first = t;
        last = t;
        got++;
      end
    end
    check("b2b_count", got, 80);
    check("b2b_no_gap", last - first, 79);
    idle(2);

    // Duplicate hi request mid-fill; count floors at zero
    step(1, 0, 0, '0, 2'd1, a);
    idle(3);
    step(1, 0, 0, '0, 2'd2, a);
    idle(1);
    feed(3, 10, "dup_pre_pixels");
    step(1, 0, 1, 16'($urandom), 2'd1, a);
    feed(idxq.size(), 300, "dup_drain");
    idle(3);

    // Random traffic: requests only for halves not already queued
    for (int t = 0; t < 400; t++) begin
      nd = 2'd0;
      if (mstart && $urandom_range(0, 7) == 0) begin
        nd = 2'($urandom_range(1, 2));
        if (has_half(nd == 2'd1)) nd = 2'd0;
      end
      step(1, 0, ($urandom_range(0, 3) != 0), 16'($urandom), nd, a);
    end
    feed(idxq.size(), 300, "rand_drain");
    idle(2);

    // Zoom in the middle of a lower-half fill
    step(1, 0, 0, '0, 2'd2, a);
    feed(10, 20, "zoom_pre_pixels");
    repeat (3) step(1, 1, 1, 16'($urandom), 2'd0, a);
    check("zoom_start_cleared", start, 0);
    check("zoom_count_cleared", store_coun, 0);
    feed(80, 120, "zoom_reprime");
    check("zoom_reprimed", start, 1);
    idle(2);

    // Reset pulse mid-fill
    step(1, 0, 0, '0, 2'd1, a);
    feed(5, 10, "rst_pre_pixels");
    step(0, 0, 1, 16'($urandom), 2'd0, a);
    feed(80, 120, "rst_reprime");
    idle(2);

    @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
